// File: rtl/line_buffer_frame_sequencer.sv
// Streams one frame of pixels from upstream memory into the convolution line buffer,
// then appends zero rows so the line buffer's output lag drains completely.
module line_buffer_frame_sequencer #(
    parameter int HRES            = 1280,
    parameter int VRES            = 720,
    parameter int KERNEL_SIZE     = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_in,
    input  logic        abort_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        rd_req_out,
    input  logic        rd_ready_in,
    output logic [19:0] rd_addr_out,
    input  logic        rd_valid_in,
    input  logic [15:0] rd_data_in,
    output logic [15:0] pixel_data_out,
    output logic [10:0] h_count_out,
    output logic [9:0]  v_count_out,
    output logic        data_valid_out
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [19:0]   TOTAL_PIX  = 20'(HRES * VRES);
    localparam logic [19:0]   LAST_ADDR  = 20'(HRES * VRES - 1);
    localparam logic [10:0]   H_LAST     = 11'(HRES - 1);
    localparam logic [9:0]    V_LAST     = 10'(VRES - 1);
    localparam logic [9:0]    FLUSH_LAST = 10'(KERNEL_SIZE - 2);
    localparam logic [OW-1:0] MAX_OUT    = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] ONE_OUT    = OW'(1);
    localparam logic [OW-1:0] ZERO_OUT   = OW'(0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_r;
    logic [19:0]     addr_r;
    logic [19:0]     resp_cnt_r;
    logic [OW-1:0]   outstanding_r;
    logic [10:0]     h_r;
    logic [9:0]      v_r;
    logic            accept_s;
    logic            resp_s;
    logic            take_s;

    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign accept_s    = rd_req_out & rd_ready_in;
    assign resp_s      = rd_valid_in & (outstanding_r != ZERO_OUT);
    assign take_s      = resp_s & ((state_r == FETCH) | (state_r == DRAIN)) & ~abort_in;
    assign rd_req_out  = (state_r == FETCH) & (outstanding_r < MAX_OUT);
    assign busy_out    = (state_r != IDLE);
    assign done_out    = (state_r == DONE);
    assign rd_addr_out = addr_r;

    // Outstanding-read counter; keeps tracking late responses after an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= ZERO_OUT;
        end else if (accept_s && !resp_s) begin
            outstanding_r <= outstanding_r + ONE_OUT;
        end else if (!accept_s && resp_s) begin
            outstanding_r <= outstanding_r - ONE_OUT;
        end else begin
            outstanding_r <= outstanding_r;
        end
    end

    // Frame sequencer: request addressing, response tagging and flush-row generation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            addr_r         <= 20'd0;
            resp_cnt_r     <= 20'd0;
            h_r            <= 11'd0;
            v_r            <= 10'd0;
            pixel_data_out <= 16'd0;
            h_count_out    <= 11'd0;
            v_count_out    <= 10'd0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (abort_in && (state_r != IDLE)) begin
                state_r    <= IDLE;
                h_r        <= 11'd0;
                v_r        <= 10'd0;
                resp_cnt_r <= 20'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_in && !abort_in && (outstanding_r == ZERO_OUT)) begin
                            state_r    <= FETCH;
                            addr_r     <= 20'd0;
                            resp_cnt_r <= 20'd0;
                            h_r        <= 11'd0;
                            v_r        <= 10'd0;
                        end
                    end
                    FETCH: begin
                        if (accept_s && (addr_r == LAST_ADDR)) begin
                            state_r <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // The last real pixel is already on the outputs when this fires.
                        if (resp_cnt_r == TOTAL_PIX) begin
                            state_r <= FLUSH;
                            h_r     <= 11'd0;
                            v_r     <= 10'd0;
                        end
                    end
                    FLUSH: begin
                        data_valid_out <= 1'b1;
                        pixel_data_out <= 16'd0;
                        h_count_out    <= h_r;
                        v_count_out    <= v_r;
                        if (h_r == H_LAST) begin
                            h_r <= 11'd0;
                            if (v_r == FLUSH_LAST) begin
                                state_r <= DONE;
                            end else begin
                                v_r <= v_r + 10'd1;
                            end
                        end else begin
                            h_r <= h_r + 11'd1;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase

                if (accept_s) begin
                    addr_r <= addr_r + 20'd1;
                end

                if (take_s) begin
                    data_valid_out <= 1'b1;
                    pixel_data_out <= rd_data_in;
                    h_count_out    <= h_r;
                    v_count_out    <= v_r;
                    resp_cnt_r     <= resp_cnt_r + 20'd1;
                    if (h_r == H_LAST) begin
                        h_r <= 11'd0;
                        v_r <= (v_r == V_LAST) ? 10'd0 : v_r + 10'd1;
                    end else begin
                        h_r <= h_r + 11'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected pixels, a monitor pops and compares them,
// and a memory model answers reads in order while checking the request stream.
module tb_line_buffer_frame_sequencer;
    localparam int HRES  = 8;
    localparam int VRES  = 4;
    localparam int KS    = 3;
    localparam int MAXO  = 4;
    localparam int TOTAL = HRES * VRES;

    logic        clk;
    logic        rst;
    logic        start_in;
    logic        abort_in;
    logic        busy_out;
    logic        done_out;
    logic        rd_req_out;
    logic        rd_ready_in;
    logic [19:0] rd_addr_out;
    logic        rd_valid_in;
    logic [15:0] rd_data_in;
    logic [15:0] pixel_data_out;
    logic [10:0] h_count_out;
    logic [9:0]  v_count_out;
    logic        data_valid_out;

    line_buffer_frame_sequencer #(
        .HRES(HRES), .VRES(VRES), .KERNEL_SIZE(KS), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .abort_in(abort_in),
        .busy_out(busy_out), .done_out(done_out), .rd_req_out(rd_req_out),
        .rd_ready_in(rd_ready_in), .rd_addr_out(rd_addr_out),
        .rd_valid_in(rd_valid_in), .rd_data_in(rd_data_in),
        .pixel_data_out(pixel_data_out), .h_count_out(h_count_out),
        .v_count_out(v_count_out), .data_valid_out(data_valid_out)
    );

    typedef struct {
        logic [19:0] addr;
        int          due;
    } req_t;

    logic [36:0] exp_q[$];   // {data, h, v}
    req_t        mem_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          lat = 2;
    int          ready_mode = 0;
    int          acc_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented pixel against the scoreboard, count done pulses.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                exp_q.delete();
            end else begin
                if (data_valid_out) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pixel: got d=%0h h=%0d v=%0d expected none",
                                 pixel_data_out, h_count_out, v_count_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {27'd0, pixel_data_out, h_count_out, v_count_out}, {27'd0, e});
                    end
                end
                if (done_out) done_cnt++;
            end
        end
    end

    // Memory model: drives ready/valid, checks request gating, addresses and stall hold.
    initial begin
        int          cyc = 0;
        bit          fetch_ph = 1'b0;
        bit          stalled = 1'b0;
        logic [19:0] exp_addr = 20'd0;
        logic [19:0] held = 20'd0;
        req_t        r;
        rd_ready_in = 1'b0;
        rd_valid_in = 1'b0;
        rd_data_in  = 16'd0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                mem_q.delete();
                fetch_ph    = 1'b0;
                stalled     = 1'b0;
                rd_valid_in = 1'b0;
                rd_ready_in = 1'b0;
            end else begin
                check("rd_req", {63'd0, rd_req_out}, {63'd0, (fetch_ph && (mem_q.size() < MAXO))});
                if (stalled && rd_req_out) check("addr_hold", {44'd0, rd_addr_out}, {44'd0, held});
                if (abort_in && busy_out) begin
                    fetch_ph = 1'b0;
                end else if (start_in && !abort_in && !busy_out && (mem_q.size() == 0)) begin
                    fetch_ph = 1'b1;
                    exp_addr = 20'd0;
                    acc_cnt  = 0;
                end
                case (ready_mode)
                    0:       rd_ready_in = 1'b1;
                    1:       rd_ready_in = ($urandom_range(0, 1) == 1);
                    default: rd_ready_in = (acc_cnt < 3);
                endcase
                if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
                    r = mem_q.pop_front();
                    rd_valid_in = 1'b1;
                    rd_data_in  = r.addr[15:0];
                end else begin
                    rd_valid_in = 1'b0;
                end
                if (rd_req_out && rd_ready_in) begin
                    check("rd_addr", {44'd0, rd_addr_out}, {44'd0, exp_addr});
                    r.addr = rd_addr_out;
                    r.due  = cyc + lat;
                    mem_q.push_back(r);
                    exp_addr = exp_addr + 20'd1;
                    acc_cnt++;
                    if (exp_addr == 20'(TOTAL)) fetch_ph = 1'b0;
                end
                stalled = rd_req_out && !rd_ready_in;
                held    = rd_addr_out;
                cyc++;
            end
        end
    end

    task automatic push_frame();
        for (int i = 0; i < TOTAL; i++)
            exp_q.push_back({16'(i), 11'(i % HRES), 10'(i / HRES)});
        for (int j = 0; j < (KS - 1) * HRES; j++)
            exp_q.push_back({16'd0, 11'(j % HRES), 10'(j / HRES)});
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start_in = 1'b1;
        @(posedge clk); #2 start_in = 1'b0;
    endtask

    task automatic run_frame(input int l, input int m, input bit mid_start);
        int d0;
        lat = l;
        ready_mode = m;
        push_frame();
        d0 = done_cnt;
        pulse_start();
        if (mid_start) begin
            repeat (10) @(posedge clk);
            #2 start_in = 1'b1;
            @(posedge clk); #1 check("busy_hold", {63'd0, busy_out}, 64'd1);
            #1 start_in = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
        check("done_once", done_cnt, d0 + 1);
        repeat (3) @(negedge clk);
        check("frame_drained", exp_q.size(), 0);
        check("busy_idle", {63'd0, busy_out}, 64'd0);
        check("done_single", done_cnt, d0 + 1);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        start_in = 1'b0;
        abort_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", {3'd0, busy_out, done_out, rd_req_out, data_valid_out,
                 rd_addr_out, pixel_data_out, h_count_out, v_count_out}, 64'd0);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Nominal frame, then long latency, random stall, and saturated window with a stray start.
        run_frame(2, 0, 1'b0);
        run_frame(10, 0, 1'b0);
        run_frame(3, 1, 1'b0);
        run_frame(4, 0, 1'b1);

        // Abort with three reads in flight; late data must vanish and start must wait.
        lat = 10;
        ready_mode = 2;
        pulse_start();
        for (int i = 0; i < 200 && acc_cnt < 3; i++) @(posedge clk);
        #2 abort_in = 1'b1;
        @(posedge clk); #1 check("abort_idle", {62'd0, busy_out, rd_req_out}, 64'd0);
        #1 abort_in = 1'b0;
        check("inflight_after_abort", mem_q.size(), 3);
        @(posedge clk); #2 start_in = 1'b1;
        @(posedge clk); #1 check("start_ignored", {63'd0, busy_out}, 64'd0);
        #1 start_in = 1'b0;
        for (int i = 0; i < 200 && mem_q.size() != 0; i++) @(negedge clk);
        check("abort_drain", mem_q.size(), 0);
        repeat (3) @(negedge clk);
        run_frame(2, 0, 1'b0);

        // Asynchronous reset in the middle of the flush rows.
        lat = 2;
        ready_mode = 0;
        push_frame();
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 2000 && exp_q.size() > 10; i++) @(negedge clk);
        check("reached_flush", exp_q.size(), 10);
        @(posedge clk); #2 rst = 1'b1;
        #1 check("async_reset", {3'd0, busy_out, done_out, rd_req_out, data_valid_out,
                 rd_addr_out, pixel_data_out, h_count_out, v_count_out}, 64'd0);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_reset", done_cnt, d0);
        check("idle_after_reset", {63'd0, busy_out}, 64'd0);
        run_frame(2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
